// File: rtl/mult_share_pkg.sv
// Shared types for the multiplier-sharing scheduler.
// Holds the FSM state encoding and the requester-id width helper.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Id width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr.
// Ports: req, ptr in; one-hot grant, grant_id, any out.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        sel      = '0;
        // Scan offsets 0..NUM_REQ-1 from ptr, wrapping modulo NUM_REQ.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            sel = idx[ID_W-1:0];
            if (!any && req[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                grant_id   = sel;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one multi-cycle signed multiplier.
// Ports: req_* handshake in, rsp_* result out, mul_* start/done to core.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_p,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     busy
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]    mul_a_q, mul_a_d;
    logic [WIDTH-1:0]    mul_b_q, mul_b_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]  rsp_p_q, rsp_p_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rsp_id_q <= '0;
            rsp_p_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rsp_id_q <= rsp_id_d;
            rsp_p_q  <= rsp_p_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        rsp_id_d = rsp_id_q;
        rsp_p_d  = rsp_p_q;
        unique case (state_q)
            IDLE: begin
                // In IDLE, any pending request implies its ready is high.
                if (any) begin
                    state_d  = ISSUE;
                    mul_a_d  = req_a[grant_id*WIDTH +: WIDTH];
                    mul_b_d  = req_b[grant_id*WIDTH +: WIDTH];
                    rsp_id_d = grant_id;
                    ptr_d    = (grant_id == ID_W'(NUM_REQ - 1))
                             ? '0 : grant_id + ID_W'(1);
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_done) begin
                    rsp_p_d = mul_p;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                // Held low while reset is asserted.
                if (reset) req_ready = grant;
            end
            ISSUE: mul_start = 1'b1;
            WAIT: ;
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign rsp_id = rsp_id_q;
    assign rsp_p  = rsp_p_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a latency-programmable
// multiplier model and a response scoreboard.
module tb_mult_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] p;
    } rsp_t;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a     = '0;
    logic [N*W-1:0] req_b     = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [63:0]    rsp_p;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done  = 1'b0;
    logic [63:0]    mul_p     = '0;
    logic           busy;

    int tests = 0;
    int fails = 0;

    rsp_t exp_q[$];
    rsp_t got_q[$];

    int cyc       = 0;
    int lat       = 4;
    int acc_cyc   = 0;
    int rise_cyc  = 0;
    int hs_cyc    = 0;
    int turn_gap  = 0;
    int rv_cycles = 0;
    int start_cnt = 0;
    int oh_err    = 0;
    int rdy_cnt[N];
    logic prev_rv = 1'b0;

    mult_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done pulses lat cycles after start; not reset.
    logic [63:0] m_ea, m_eb, m_prod, m_hold = '0;
    int          m_cnt  = 0;
    logic        m_busy = 1'b0;

    assign m_ea   = {{32{mul_a[31]}}, mul_a};
    assign m_eb   = {{32{mul_b[31]}}, mul_b};
    assign m_prod = $signed(m_ea) * $signed(m_eb);

    always @(posedge clk) begin
        if (mul_start) begin
            m_hold   <= m_prod;
            m_cnt    <= lat - 1;
            m_busy   <= (lat > 1);
            mul_done <= (lat == 1);
            if (lat == 1) mul_p <= m_prod;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy   <= 1'b0;
                mul_done <= 1'b1;
                mul_p    <= m_hold;
            end else begin
                mul_done <= 1'b0;
            end
        end else begin
            mul_done <= 1'b0;
        end
    end

    // Monitor: records responses and timing events mid-cycle.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            got_q.push_back('{id: rsp_id, p: rsp_p});
            hs_cyc = cyc;
        end
        if (rsp_valid && !prev_rv) rise_cyc = cyc;
        prev_rv = rsp_valid;
        if (rsp_valid) rv_cycles++;
        if (mul_start) start_cnt++;
        if (|(req_valid & req_ready)) begin
            acc_cyc  = cyc;
            turn_gap = cyc - hs_cyc;
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i]) rdy_cnt[i]++;
        if (!$onehot0(req_ready)) oh_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [63:0] p);
        exp_q.push_back('{id: id, p: p});
    endtask

    // Runs cycles, dropping each requester's valid once accepted.
    task automatic drive_cycles(input int n_rsp, input int max_cyc,
                                output bit to);
        logic [N-1:0] acc;
        for (int k = 0; k < max_cyc; k++) begin
            if (n_rsp > 0 && got_q.size() >= n_rsp) break;
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        to = (n_rsp > 0) && (got_q.size() < n_rsp);
    endtask

    task automatic test_reset();
        req_valid = '1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl busy=%b rsp_valid=%b mul_start=%b required 0 0 0",
                     busy, rsp_valid, mul_start);
        end
        tests++;
        if (mul_a !== '0 || mul_b !== '0) begin
            fails++;
            $display("FAIL reset_ops mul_a=%h mul_b=%h required 0 0", mul_a, mul_b);
        end
        tests++;
        if (rsp_id !== 2'd0 || rsp_p !== 64'd0) begin
            fails++;
            $display("FAIL reset_rsp rsp_id=%0d rsp_p=%h required 0 0", rsp_id, rsp_p);
        end
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready req_ready=%b required 0000", req_ready);
        end
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_all_four();
        bit   to;
        rsp_t e, g;
        lat = 3;
        set_req(0, 2, 3);
        set_req(1, -12, -4);
        set_req(2, -9, 5);
        set_req(3, 11, 0);
        push_exp(0, 64'sd6);
        push_exp(1, 64'sd48);
        push_exp(2, -64'sd45);
        push_exp(3, 64'sd0);
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        oh_err = 0;
        req_valid = 4'b1111;
        drive_cycles(4, 300, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL four_timeout got %0d responses required 4", got_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL four_rsp%0d got id=%0d p=%0d required id=%0d p=%0d",
                         k, g.id, $signed(g.p), e.id, $signed(e.p));
            end
        end
        for (int i = 0; i < N; i++) begin
            tests++;
            if (rdy_cnt[i] != 1) begin
                fails++;
                $display("FAIL four_ready%0d pulses=%0d required 1", i, rdy_cnt[i]);
            end
        end
        tests++;
        if (oh_err != 0) begin
            fails++;
            $display("FAIL ready_onehot violations=%0d required 0", oh_err);
        end
    endtask

    task automatic test_single();
        bit   to;
        int   s0;
        rsp_t e, g;
        lat = 32;
        set_req(0, 5, -7);
        push_exp(0, -64'sd35);
        s0 = start_cnt;
        req_valid = 4'b0001;
        drive_cycles(1, 100, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL single_timeout got 0 responses required 1");
        end
        e = exp_q.pop_front();
        g = '0;
        if (got_q.size() > 0) g = got_q.pop_front();
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL single_rsp got id=%0d p=%0d required id=%0d p=%0d",
                     g.id, $signed(g.p), e.id, $signed(e.p));
        end
        tests++;
        if (rise_cyc - acc_cyc != 34) begin
            fails++;
            $display("FAIL single_latency got %0d required 34", rise_cyc - acc_cyc);
        end
        tests++;
        if (start_cnt - s0 != 1) begin
            fails++;
            $display("FAIL single_start cycles=%0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        bit   to;
        int   k;
        int   bad;
        rsp_t e, g;
        lat = 2;
        rsp_ready = 1'b0;
        set_req(2, 10, 1);
        push_exp(2, 64'sd10);
        req_valid = 4'b0100;
        drive_cycles(0, 3, to);
        set_req(1, 3, 3);
        push_exp(1, 64'sd9);
        req_valid[1] = 1'b1;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_wait rsp_valid=%b required 1", rsp_valid);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
                rsp_p !== 64'd10 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold v=%b id=%0d p=%0d rdy=%b required 1 2 10 0000",
                         rsp_valid, rsp_id, rsp_p, req_ready);
            end
        end
        tests++;
        if (bad != 0) fails++;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drive_cycles(2, 100, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL bp_timeout got %0d responses required 2", got_q.size());
        end
        for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL bp_rsp%0d got id=%0d p=%0d required id=%0d p=%0d",
                         j, g.id, $signed(g.p), e.id, $signed(e.p));
            end
        end
        tests++;
        if (turn_gap != 1) begin
            fails++;
            $display("FAIL turnaround gap=%0d required 1", turn_gap);
        end
    endtask

    task automatic test_extremes();
        bit   to;
        rsp_t e, g;
        lat = 1;
        set_req(0, 32'h8000_0000, 32'h8000_0000);
        set_req(1, -1, -7);
        push_exp(0, 64'h4000_0000_0000_0000);
        push_exp(1, 64'sd7);
        req_valid = 4'b0011;
        drive_cycles(2, 100, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL ext_timeout got %0d responses required 2", got_q.size());
        end
        for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL ext_rsp%0d got id=%0d p=%h required id=%0d p=%h",
                         j, g.id, g.p, e.id, e.p);
            end
        end
        tests++;
        if (rise_cyc - acc_cyc != 3) begin
            fails++;
            $display("FAIL ext_latency_l1 got %0d required 3", rise_cyc - acc_cyc);
        end
    endtask

    task automatic test_reset_mid();
        bit   to;
        int   rv0;
        rsp_t e, g;
        lat = 32;
        set_req(2, 7, 7);
        req_valid = 4'b0100;
        drive_cycles(0, 6, to);
        tests++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_inflight busy=%b rsp_valid=%b required 1 0",
                     busy, rsp_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || mul_start !== 1'b0 ||
            rsp_id !== 2'd0 || rsp_p !== 64'd0) begin
            fails++;
            $display("FAIL mid_reset busy=%b start=%b id=%0d p=%0d required 0 0 0 0",
                     busy, mul_start, rsp_id, rsp_p);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        rv0 = rv_cycles;
        drive_cycles(0, 50, to);
        tests++;
        if (rv_cycles != rv0 || got_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stale_done rsp_cycles=%0d rsps=%0d busy=%b required 0 0 0",
                     rv_cycles - rv0, got_q.size(), busy);
        end
        // ptr back at 0, so requester 1 wins over 3.
        set_req(1, 4, 6);
        set_req(3, 1, 1);
        push_exp(1, 64'sd24);
        push_exp(3, 64'sd1);
        req_valid = 4'b1010;
        drive_cycles(2, 200, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL mid_timeout got %0d responses required 2", got_q.size());
        end
        for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL mid_rsp%0d got id=%0d p=%0d required id=%0d p=%0d",
                         j, g.id, $signed(g.p), e.id, $signed(e.p));
            end
        end
    endtask

    task automatic test_ptr_wrap();
        bit   to;
        rsp_t e, g;
        lat = 4;
        set_req(3, 2, 2);
        push_exp(3, 64'sd4);
        req_valid = 4'b1000;
        drive_cycles(1, 100, to);
        set_req(0, 3, -3);
        set_req(3, -5, -5);
        push_exp(0, -64'sd9);
        push_exp(3, 64'sd25);
        req_valid = 4'b1001;
        drive_cycles(3, 100, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL wrap_timeout got %0d responses required 3", got_q.size());
        end
        for (int j = 0; j < 3; j++) begin
            e = exp_q.pop_front();
            g = '0;
            if (got_q.size() > 0) g = got_q.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL wrap_rsp%0d got id=%0d p=%0d required id=%0d p=%0d",
                         j, g.id, $signed(g.p), e.id, $signed(e.p));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        test_reset();
        test_all_four();
        test_single();
        test_backpressure();
        test_extremes();
        test_reset_mid();
        test_ptr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
